// File: rtl/audio_pkg.sv
// ----------------------------------------------------------------------------
// audio_pkg
//   Definitions shared by the audio path: the ADC receiver (audio_in), the
//   effect stages and the DAC serializer.
//   - AUDIO_W      : native sample width of the audio path.
//   - chan_e       : channel encoding, identical to the I2S LRCLK level.
//   - audio_in_state_e : receiver framing states.
// ----------------------------------------------------------------------------
package audio_pkg;

  localparam int AUDIO_W = 16;

  // LRCLK level of each channel slot.
  typedef enum logic {
    LEFT  = 1'b0,
    RIGHT = 1'b1
  } chan_e;

  // ST_ALIGN : waiting for the LRCLK falling edge that opens a left slot.
  // ST_SKIP  : dropping the I2S_DELAY bit clocks that precede the MSB.
  // ST_SHIFT : collecting the data bits of the current slot.
  // ST_WAIT  : word complete, ignoring slot padding until the next LRCLK edge.
  typedef enum logic [1:0] {
    ST_ALIGN = 2'd0,
    ST_SKIP  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_WAIT  = 2'd3
  } audio_in_state_e;

endpackage

// File: rtl/audio_sync_edge.sv
// ----------------------------------------------------------------------------
// audio_sync_edge
//   Multi-flop synchronizer for one asynchronous input, with optional edge
//   detection on the synchronized value. The edge outputs are decoded from
//   two flops (last synchronizer stage and its delayed copy), so they are
//   clean one-cycle pulses.
//
//   Parameters:
//     SYNC_STAGES : synchronizer depth, must be 2 or more.
//     EDGE_DETECT : 1 = generate rise/fall/any_edge, 0 = synchronizer only
//                   (edge outputs tied low).
//   Ports:
//     clk      in  system clock
//     rst_n    in  synchronous active-low reset
//     async_in in  asynchronous input
//     sync_out out synchronized level
//     rise     out one-cycle pulse on a 0->1 change of sync_out
//     fall     out one-cycle pulse on a 1->0 change of sync_out
//     any_edge out one-cycle pulse on any change of sync_out
// ----------------------------------------------------------------------------
module audio_sync_edge #(
  parameter int SYNC_STAGES = 2,
  parameter bit EDGE_DETECT = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic sync_out,
  output logic rise,
  output logic fall,
  output logic any_edge
);

  logic [SYNC_STAGES-1:0] sync_q;

  // NOTE: clocked state is always assigned with <= so every flop samples the
  // pre-edge value of its neighbours; with = the chain would collapse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
    end
  end

  assign sync_out = sync_q[SYNC_STAGES-1];

  if (EDGE_DETECT) begin : g_edge
    logic prev_q;

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        prev_q <= 1'b0;
      end else begin
        prev_q <= sync_out;
      end
    end

    assign rise     =  sync_out & ~prev_q;
    assign fall     = ~sync_out &  prev_q;
    assign any_edge =  sync_out ^  prev_q;
  end else begin : g_no_edge
    assign rise     = 1'b0;
    assign fall     = 1'b0;
    assign any_edge = 1'b0;
  end

endmodule

// File: rtl/audio_in.sv
// ----------------------------------------------------------------------------
// audio_in
//   I2S receiver for the codec ADC path. BCLK, LRCLK and ADCDAT are
//   oversampled in the CLK domain; MSB-first two's-complement words are
//   deserialized per slot and published as a coherent left/right pair.
//
//   Parameters:
//     DATA_W      : sample width (MSB first).
//     SYNC_STAGES : synchronizer depth on every codec input (2 or more).
//     I2S_DELAY   : BCLK rising edges skipped after an LRCLK edge before the
//                   MSB (1 = I2S, 0 = left-justified).
//   Ports:
//     CLK          in  system clock, at least 8x BCLK
//     RST_N        in  synchronous active-low reset
//     BCLK         in  codec bit clock (asynchronous)
//     LRCLK        in  codec word select, 0 = left, 1 = right (asynchronous)
//     ADCDAT       in  codec serial data (asynchronous)
//     left         out left sample of the last complete frame
//     right        out right sample of the last complete frame
//     sample_valid out one-CLK pulse when left/right update
//     frame_err    out one-CLK pulse when a slot ends before DATA_W bits
//     locked       out high after a complete good frame, cleared on frame_err
// ----------------------------------------------------------------------------
module audio_in
  import audio_pkg::*;
#(
  parameter int DATA_W      = AUDIO_W,
  parameter int SYNC_STAGES = 2,
  parameter int I2S_DELAY   = 1
) (
  input  logic                     CLK,
  input  logic                     RST_N,
  input  logic                     BCLK,
  input  logic                     LRCLK,
  input  logic                     ADCDAT,
  output logic signed [DATA_W-1:0] left,
  output logic signed [DATA_W-1:0] right,
  output logic                     sample_valid,
  output logic                     frame_err,
  output logic                     locked
);

  // The counter serves both the SKIP phase and the bit count.
  localparam int CNT_MAX = (DATA_W > I2S_DELAY) ? DATA_W : I2S_DELAY;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  // --------------------------------------------------------------------------
  // Input conditioning
  // --------------------------------------------------------------------------
  logic bclk_rise, lr_fall, lr_edge, dat_s;
  logic bclk_sync_unused, bclk_fall_unused, bclk_any_unused;
  logic lr_sync_unused, lr_rise_unused;
  logic dat_rise_unused, dat_fall_unused, dat_any_unused;

  audio_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .EDGE_DETECT(1'b1)) u_bclk_sync (
    .clk      (CLK),
    .rst_n    (RST_N),
    .async_in (BCLK),
    .sync_out (bclk_sync_unused),
    .rise     (bclk_rise),
    .fall     (bclk_fall_unused),
    .any_edge (bclk_any_unused)
  );

  audio_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .EDGE_DETECT(1'b1)) u_lrclk_sync (
    .clk      (CLK),
    .rst_n    (RST_N),
    .async_in (LRCLK),
    .sync_out (lr_sync_unused),
    .rise     (lr_rise_unused),
    .fall     (lr_fall),
    .any_edge (lr_edge)
  );

  // Same depth as BCLK, so the data level seen on bclk_rise is the one the
  // codec presented at that BCLK rising edge.
  audio_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .EDGE_DETECT(1'b0)) u_adcdat_sync (
    .clk      (CLK),
    .rst_n    (RST_N),
    .async_in (ADCDAT),
    .sync_out (dat_s),
    .rise     (dat_rise_unused),
    .fall     (dat_fall_unused),
    .any_edge (dat_any_unused)
  );

  // --------------------------------------------------------------------------
  // Framing FSM and datapath
  // --------------------------------------------------------------------------
  audio_in_state_e    state_q, state_d;
  chan_e              chan_q, chan_d, next_chan;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0]  shift_q, shift_d;
  logic [DATA_W-1:0]  hold_l_q, hold_l_d, hold_r_q, hold_r_d;
  logic [DATA_W-1:0]  left_d, right_d;
  logic               valid_d, err_d, locked_d;
  logic               start_slot, take_bit;

  // NOTE: every variable written here gets a default before any branch, so
  // no path leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    chan_d     = chan_q;
    cnt_d      = cnt_q;
    shift_d    = shift_q;
    hold_l_d   = hold_l_q;
    hold_r_d   = hold_r_q;
    left_d     = left;
    right_d    = right;
    valid_d    = 1'b0;
    err_d      = 1'b0;
    locked_d   = locked;
    start_slot = 1'b0;
    next_chan  = LEFT;
    take_bit   = 1'b0;

    // Slot boundaries (LRCLK edges) take priority over bit clocks.
    unique case (state_q)
      ST_ALIGN: begin
        if (lr_fall) begin
          start_slot = 1'b1;
          next_chan  = LEFT;
        end
      end
      ST_SKIP, ST_SHIFT: begin
        // Slot closed before DATA_W bits: drop the frame and realign.
        if (lr_edge) begin
          state_d  = ST_ALIGN;
          cnt_d    = '0;
          shift_d  = '0;
          hold_l_d = '0;
          err_d    = 1'b1;
          locked_d = 1'b0;
        end
      end
      ST_WAIT: begin
        if (lr_edge) begin
          start_slot = 1'b1;
          if (chan_q == LEFT) begin
            next_chan = RIGHT;
          end else begin
            // Both words are held; publish them together.
            next_chan = LEFT;
            left_d    = hold_l_q;
            right_d   = hold_r_q;
            valid_d   = 1'b1;
            locked_d  = 1'b1;
          end
        end
      end
      default: state_d = ST_ALIGN;
    endcase

    if (start_slot) begin
      chan_d  = next_chan;
      cnt_d   = '0;
      shift_d = '0;
      state_d = (I2S_DELAY == 0) ? ST_SHIFT : ST_SKIP;
    end

    // A bclk_rise coinciding with the slot-opening LRCLK edge belongs to the
    // new slot (LRCLK moves on the BCLK falling edge, so this rise is the
    // first one of the slot).
    take_bit = bclk_rise &&
               (start_slot ||
                (!lr_edge && (state_q == ST_SKIP || state_q == ST_SHIFT)));

    if (take_bit) begin
      if (state_d == ST_SKIP) begin
        if (int'(cnt_d) == I2S_DELAY - 1) begin
          state_d = ST_SHIFT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_d + CNT_W'(1);
        end
      end else begin
        shift_d = {shift_d[DATA_W-2:0], dat_s};
        cnt_d   = cnt_d + CNT_W'(1);
        if (int'(cnt_d) == DATA_W) begin
          if (chan_d == LEFT) begin
            hold_l_d = shift_d;
          end else begin
            hold_r_d = shift_d;
          end
          state_d = ST_WAIT;
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q      <= ST_ALIGN;
      chan_q       <= LEFT;
      cnt_q        <= '0;
      shift_q      <= '0;
      hold_l_q     <= '0;
      hold_r_q     <= '0;
      left         <= '0;
      right        <= '0;
      sample_valid <= 1'b0;
      frame_err    <= 1'b0;
      locked       <= 1'b0;
    end else begin
      state_q      <= state_d;
      chan_q       <= chan_d;
      cnt_q        <= cnt_d;
      shift_q      <= shift_d;
      hold_l_q     <= hold_l_d;
      hold_r_q     <= hold_r_d;
      left         <= left_d;
      right        <= right_d;
      sample_valid <= valid_d;
      frame_err    <= err_d;
      locked       <= locked_d;
    end
  end

endmodule
